// File: rtl/updown_counter.sv
// Up/down modulo-(G_MAX+1) counter with load, optional saturation and a registered terminal-count pulse.
// Define UPDOWN_COUNTER_PRESCALE_EN to insert a G_PRESCALE enable divider in front of the step logic.
module updown_counter #(
    parameter int                 G_WIDTH    = 8,
    parameter logic [G_WIDTH-1:0] G_MAX      = '1,
    parameter int                 G_SATURATE = 0,
    parameter int                 G_PRESCALE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [G_WIDTH-1:0] load_val,
    output logic [G_WIDTH-1:0] out,
    output logic               tc
);

    if (G_WIDTH < 2 || G_WIDTH > 32) begin : g_bad_width
        $error("updown_counter: G_WIDTH out of range 2..32");
    end
    if (G_MAX == '0) begin : g_bad_max
        $error("updown_counter: G_MAX must be at least 1");
    end
    if (G_PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter: G_PRESCALE must be at least 1");
    end

    function automatic logic [G_WIDTH-1:0] clamp_load(input logic [G_WIDTH-1:0] v);
        return (v > G_MAX) ? G_MAX : v;
    endfunction

    function automatic logic at_boundary(input logic [G_WIDTH-1:0] cur, input logic dir);
        return dir ? (cur == G_MAX) : (cur == '0);
    endfunction

    // Boundary handling (wrap vs. hold) lives here so the register process stays a plain priority chain.
    function automatic logic [G_WIDTH-1:0] next_count(input logic [G_WIDTH-1:0] cur, input logic dir);
        if (at_boundary(cur, dir)) begin
            if (G_SATURATE != 0) begin
                return cur;
            end
            return dir ? '0 : G_MAX;
        end
        return dir ? cur + 1'b1 : cur - 1'b1;
    endfunction

    logic step_req;
    logic step;

    assign step_req = en & ~load;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int            PW     = (G_PRESCALE > 1) ? $clog2(G_PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(G_PRESCALE - 1);

    logic [PW-1:0] presc;

    // Divider advances on every enabled non-load edge; direction changes leave it alone.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
        end
    end

    assign step = step_req && (presc == P_LAST);
`else
    assign step = step_req;
`endif

    // Count register: reset > load > step > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            out <= clamp_load(load_val);
            tc  <= 1'b0;
        end else if (step) begin
            out <= next_count(out, up);
            tc  <= at_boundary(out, up);
        end else begin
            tc  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: wrap and saturate instances (G_WIDTH=4, G_MAX=9) plus a prescaled instance.
// Prescale expectations are checked only when UPDOWN_COUNTER_PRESCALE_EN is defined.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] out_w, out_s, out_p;
    logic       tc_w, tc_s, tc_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PS_PLAIN = 1;
`else
    localparam int PS_PLAIN = 4;
`endif

    updown_counter #(.G_WIDTH(4), .G_MAX(4'd9), .G_SATURATE(0), .G_PRESCALE(PS_PLAIN)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .out(out_w), .tc(tc_w)
    );

    updown_counter #(.G_WIDTH(4), .G_MAX(4'd9), .G_SATURATE(1), .G_PRESCALE(PS_PLAIN)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .out(out_s), .tc(tc_s)
    );

    updown_counter #(.G_WIDTH(4), .G_MAX(4'd9), .G_SATURATE(0), .G_PRESCALE(4)) dut_p (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .out(out_p), .tc(tc_p)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
        reset    = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = v;
    endtask

    logic [3:0] exp_up_w [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] exp_up_s [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    logic       exp_tc_w [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       exp_tc_s [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [3:0] exp_dn_w [5]  = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    logic       exp_dn_tc[5]  = '{0, 0, 0, 1, 0};
    logic [3:0] exp_sat_o[4]  = '{4'd9, 4'd9, 4'd9, 4'd9};
    logic       exp_sat_t[4]  = '{0, 1, 1, 1};
    logic [3:0] exp_wr_o [4]  = '{4'd9, 4'd0, 4'd1, 4'd2};
    logic       exp_wr_t [4]  = '{0, 1, 0, 0};

    initial begin
        drive(1, 0, 1, 0, 4'd0);

        // Reset state
        tick();
        chk("reset_out_w", out_w, 0);
        chk("reset_tc_w", tc_w, 0);
        chk("reset_out_s", out_s, 0);
        chk("reset_out_p", out_p, 0);

        // Count up 12 cycles through the wrap
        drive(0, 1, 1, 0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("up_out_w[%0d]", i), out_w, exp_up_w[i]);
            chk($sformatf("up_tc_w[%0d]", i), tc_w, exp_tc_w[i]);
            chk($sformatf("up_out_s[%0d]", i), out_s, exp_up_s[i]);
            chk($sformatf("up_tc_s[%0d]", i), tc_s, exp_tc_s[i]);
`ifdef UPDOWN_COUNTER_PRESCALE_EN
            chk($sformatf("psc_out[%0d]", i), out_p, 4'((i + 1) / 4));
            chk($sformatf("psc_tc[%0d]", i), tc_p, 0);
`endif
        end

        // Load 3 with en=1 (en/up ignored), then count down through 0
        drive(0, 1, 0, 1, 4'd3);
        tick();
        chk("load3_out_w", out_w, 3);
        chk("load3_tc_w", tc_w, 0);
        chk("load3_out_s", out_s, 3);
        drive(0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("dn_out_w[%0d]", i), out_w, exp_dn_w[i]);
            chk($sformatf("dn_tc_w[%0d]", i), tc_w, exp_dn_tc[i]);
        end

        // Saturate at the top vs. wrap
        drive(0, 0, 1, 1, 4'd8);
        tick();
        chk("load8_out_s", out_s, 8);
        drive(0, 1, 1, 0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("sat_out_s[%0d]", i), out_s, exp_sat_o[i]);
            chk($sformatf("sat_tc_s[%0d]", i), tc_s, exp_sat_t[i]);
            chk($sformatf("sat_out_w[%0d]", i), out_w, exp_wr_o[i]);
            chk($sformatf("sat_tc_w[%0d]", i), tc_w, exp_wr_t[i]);
        end

        // Load beats step on the same edge and clears a high tc
        drive(0, 1, 1, 1, 4'd2);
        tick();
        chk("ld_en_out_s", out_s, 2);
        chk("ld_en_tc_s", tc_s, 0);
        chk("ld_en_out_w", out_w, 2);

        // Load above G_MAX clamps
        drive(0, 0, 1, 1, 4'd15);
        tick();
        chk("clamp_out_w", out_w, 9);
        chk("clamp_out_s", out_s, 9);
        chk("clamp_tc_w", tc_w, 0);

        // en=0 holds
        drive(0, 0, 1, 0, 4'd0);
        tick();
        chk("hold_out_w", out_w, 9);
        chk("hold_tc_w", tc_w, 0);

        // Down step at 0: wrap to G_MAX vs. hold at 0, tc in both modes
        drive(0, 0, 0, 1, 4'd0);
        tick();
        chk("load0_out_w", out_w, 0);
        drive(0, 1, 0, 0, 4'd0);
        tick();
        chk("dn0_out_w", out_w, 9);
        chk("dn0_tc_w", tc_w, 1);
        chk("dn0_out_s", out_s, 0);
        chk("dn0_tc_s", tc_s, 1);

        // Direction changes every cycle with no penalty
        drive(0, 0, 1, 1, 4'd4);
        tick();
        drive(0, 1, 1, 0, 4'd0);
        tick();
        chk("dir_up_w", out_w, 5);
        up = 1'b0;
        tick();
        chk("dir_dn_w", out_w, 4);
        up = 1'b1;
        tick();
        chk("dir_up2_w", out_w, 5);

        // Reset mid-count overrides load and en, then counting resumes
        drive(1, 1, 1, 1, 4'd7);
        tick();
        chk("rst_mid_out_w", out_w, 0);
        chk("rst_mid_tc_w", tc_w, 0);
        drive(0, 1, 1, 0, 4'd0);
        tick();
        chk("resume1_w", out_w, 1);
        tick();
        chk("resume2_w", out_w, 2);

`ifdef UPDOWN_COUNTER_PRESCALE_EN
        chk("psc_after_rst", out_p, 0);
        // Load clears the divider; a direction change does not
        drive(0, 0, 1, 1, 4'd0);
        tick();
        drive(0, 1, 1, 0, 4'd0);
        tick();
        tick();
        tick();
        chk("psc_partial", out_p, 0);
        up = 1'b0;
        tick();
        chk("psc_dirflip_out", out_p, 9);
        chk("psc_dirflip_tc", tc_p, 1);
        up = 1'b1;
        tick();
        tick();
        chk("psc_mid_out", out_p, 9);
        drive(0, 1, 1, 1, 4'd5);
        tick();
        drive(0, 1, 1, 0, 4'd0);
        tick();
        tick();
        tick();
        chk("psc_ldclr_3", out_p, 5);
        tick();
        chk("psc_ldclr_4", out_p, 6);
        chk("psc_ldclr_tc", tc_p, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
